// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb_if
//  Brief    : Requester and uart_tx handshake bundle for uart_tx_arb.
//             master = arbiter side, slave = requesters plus serializer.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arb_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] data;
   logic [N_REQ-1:0]   last;
   logic [N_REQ-1:0]   ack;
   logic [N_REQ-1:0]   grant;
   logic [2:0]         owner;
   logic [7:0]         tx_data;
   logic               tx_en;
   logic               tx_busy;

   modport master (
      input  req, data, last, tx_busy,
      output ack, grant, owner, tx_data, tx_en
   );

   modport slave (
      output req, data, last, tx_busy,
      input  ack, grant, owner, tx_data, tx_en
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Brief    : Round-robin, packet-locked arbiter sharing one uart_tx between
//             N_REQ byte sources, with a per-grant idle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255
) (
   input  wire logic     CLK,
   input  wire logic     resetn,
   uart_tx_arb_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK  = 2'd1,
      ST_SEND  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [7:0]       c_timeout  = 8'(TIMEOUT);
   localparam logic [2:0]       c_last_idx = 3'(N_REQ - 1);
   localparam logic [N_REQ-1:0] c_one      = N_REQ'(1);

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       owner_q, owner_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_en_q, tx_en_d;
   logic [7:0]       idle_cnt_q, idle_cnt_d;
   logic             pkt_end_q, pkt_end_d;

   logic             own_req;
   logic             own_last;
   logic [7:0]       own_data;
   logic             found_hi, found_lo;
   logic [2:0]       sel_hi, sel_lo, sel;
   logic [2:0]       ptr_after_owner;
   logic [7:0]       idle_inc;

   // Pick out the current owner's request, byte and last flag.
   always_comb begin
      own_req  = 1'b0;
      own_last = 1'b0;
      own_data = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == 3'(i)) begin
            own_req  = bus.req[i];
            own_last = bus.last[i];
            own_data = bus.data[8*i +: 8];
         end
      end
   end

   // Round-robin search: lowest request at or above ptr, else lowest overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      sel_hi   = 3'd0;
      sel_lo   = 3'd0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            found_lo = 1'b1;
            sel_lo   = 3'(i);
            if (3'(i) >= ptr_q) begin
               found_hi = 1'b1;
               sel_hi   = 3'(i);
            end
         end
      end
      sel = found_hi ? sel_hi : sel_lo;
   end

   // Next-state and next-output computation for the arbiter FSM.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      ack_d      = '0;
      tx_en_d    = 1'b0;
      tx_data_d  = tx_data_q;
      idle_cnt_d = idle_cnt_q;
      pkt_end_d  = pkt_end_q;

      ptr_after_owner = (owner_q == c_last_idx) ? 3'd0 : owner_q + 3'd1;
      idle_inc        = idle_cnt_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            if (found_lo) begin
               owner_d    = sel;
               grant_d    = c_one << sel;
               idle_cnt_d = 8'd0;
               state_d    = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (own_req) begin
               // A requesting owner with a busy serializer simply waits.
               if (!bus.tx_busy) begin
                  tx_data_d  = own_data;
                  tx_en_d    = 1'b1;
                  ack_d      = c_one << owner_q;
                  pkt_end_d  = own_last;
                  idle_cnt_d = 8'd0;
                  state_d    = ST_SEND;
               end
            end else if (idle_inc >= c_timeout) begin
               idle_cnt_d = c_timeout;
               grant_d    = '0;
               ptr_d      = ptr_after_owner;
               state_d    = ST_IDLE;
            end else begin
               idle_cnt_d = idle_inc;
            end
         end
         ST_SEND: begin
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!bus.tx_busy) begin
               if (pkt_end_q) begin
                  grant_d = '0;
                  ptr_d   = ptr_after_owner;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_LOCK;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight byte.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 3'd0;
         owner_q    <= 3'd0;
         grant_q    <= '0;
         ack_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_en_q    <= 1'b0;
         idle_cnt_q <= 8'd0;
         pkt_end_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         tx_data_q  <= tx_data_d;
         tx_en_q    <= tx_en_d;
         idle_cnt_q <= idle_cnt_d;
         pkt_end_q  <= pkt_end_d;
      end
   end

   assign bus.ack     = ack_q;
   assign bus.grant   = grant_q;
   assign bus.owner   = owner_q;
   assign bus.tx_data = tx_data_q;
   assign bus.tx_en   = tx_en_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Brief    : Self-checking bench for uart_tx_arb with requester queues, a
//             uart_tx busy model and a per-requester byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

   localparam int N     = 4;
   localparam int TMO   = 8;
   localparam int FRAME = 6;

   logic CLK;
   logic resetn;

   uart_tx_arb_if #(.N_REQ(N)) bus ();

   uart_tx_arb #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .CLK    (CLK),
      .resetn (resetn),
      .bus    (bus)
   );

   logic [8:0] rq [N][$];   // {last, data} still to be offered per requester
   logic [8:0] sb [N][$];   // expected bytes per requester
   int         served[$];   // requester index of every ack, in order
   logic [N-1:0] en;
   int         n_chk;
   int         n_pass;
   int         busy_cnt;
   bit         start_next;
   bit         prev_en;

   typedef struct {
      int         setup;      // requester sent first to place ptr, -1 = none
      logic [3:0] mask;       // requesters raised together
      logic [3:0] exp_grant;
      logic [2:0] exp_owner;
   } vec_t;

   vec_t vecs[6];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic monitor_byte();
      int         idx;
      logic [8:0] e;
      idx = -1;
      for (int i = 0; i < N; i++) if (bus.ack[i]) idx = i;
      check("tx_en_single_cycle", 32'(prev_en), 32'd0);
      check("ack_onehot", 32'($countones(bus.ack)), 32'd1);
      check("ack_matches_owner", 32'(bus.ack), 32'(4'b0001 << bus.owner));
      check("grant_matches_ack", 32'(bus.grant), 32'(bus.ack));
      if (idx >= 0) begin
         check("byte_expected", 32'(sb[idx].size() != 0), 32'd1);
         if (sb[idx].size() != 0) begin
            e = sb[idx].pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
         end
         if (rq[idx].size() != 0) void'(rq[idx].pop_front());
         served.push_back(idx);
      end
   endtask

   task automatic drive_reqs();
      logic [8:0] h;
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() != 0) begin
            h                 = rq[i][0];
            bus.req[i]        = en[i];
            bus.data[8*i +: 8] = h[7:0];
            bus.last[i]       = h[8];
         end else begin
            bus.req[i] = 1'b0;
         end
      end
   endtask

   // Requester, serializer and monitor model, sampled 1 ns after each edge.
   initial begin
      bus.tx_busy = 1'b0;
      bus.req     = '0;
      bus.data    = '0;
      bus.last    = '0;
      busy_cnt    = 0;
      start_next  = 1'b0;
      prev_en     = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (!resetn) begin
            busy_cnt   = 0;
            start_next = 1'b0;
            prev_en    = 1'b0;
         end else begin
            if (bus.tx_en) monitor_byte();
            prev_en = bus.tx_en;
            if (busy_cnt > 0) busy_cnt--;
            if (start_next) busy_cnt = FRAME;
            start_next = bus.tx_en;
         end
         bus.tx_busy = (busy_cnt != 0);
         drive_reqs();
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic send(input int r, input logic [7:0] d, input logic l);
      rq[r].push_back({l, d});
      sb[r].push_back({l, d});
   endtask

   task automatic clear_model();
      busy_cnt    = 0;
      start_next  = 1'b0;
      prev_en     = 1'b0;
      bus.tx_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         sb[i].delete();
      end
      served.delete();
      en = '1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      clear_model();
      tick();
      tick();
      @(negedge CLK);
      resetn = 1'b1;
   endtask

   task automatic wait_served(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (served.size() < n && c < budget) begin
         tick();
         c++;
      end
      check(name, 32'(served.size()), 32'(n));
   endtask

   task automatic wait_busy_fall(input string name, input int budget);
      logic prev;
      int   c;
      bit   ok;
      ok   = 1'b0;
      c    = 0;
      prev = bus.tx_busy;
      while (!ok && c < budget) begin
         tick();
         c++;
         if (prev && !bus.tx_busy) ok = 1'b1;
         prev = bus.tx_busy;
      end
      if (!ok) check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_grant(input string name, input bit want_zero, input int budget);
      int c;
      c = 0;
      while (((bus.grant == '0) != want_zero) && c < budget) begin
         tick();
         c++;
      end
      if ((bus.grant == '0) != want_zero) check(name, 32'(bus.grant), 32'(want_zero ? 0 : 1));
   endtask

   initial begin
      int exp_order[$];
      n_chk  = 0;
      n_pass = 0;
      resetn = 1'b0;
      en     = '1;

      vecs[0] = '{setup: 0,  mask: 4'b1111, exp_grant: 4'b0010, exp_owner: 3'd1};
      vecs[1] = '{setup: 3,  mask: 4'b1010, exp_grant: 4'b0010, exp_owner: 3'd1};
      vecs[2] = '{setup: 1,  mask: 4'b0011, exp_grant: 4'b0001, exp_owner: 3'd0};
      vecs[3] = '{setup: 2,  mask: 4'b0111, exp_grant: 4'b0001, exp_owner: 3'd0};
      vecs[4] = '{setup: -1, mask: 4'b1000, exp_grant: 4'b1000, exp_owner: 3'd3};
      vecs[5] = '{setup: 2,  mask: 4'b1100, exp_grant: 4'b1000, exp_owner: 3'd3};

      // Reset with every requester asserting.
      clear_model();
      for (int i = 0; i < N; i++) send(i, 8'hA0 + 8'(i), 1'b1);
      repeat (3) tick();
      check("reset_outputs", 32'({bus.grant, bus.owner, bus.ack, bus.tx_data, bus.tx_en}), 32'd0);
      @(negedge CLK);
      resetn = 1'b1;
      tick();
      check("reset_first_grant", 32'(bus.grant), 32'h1);
      wait_served("reset_first_byte", 1, 50);
      check("reset_first_owner", 32'(served[0]), 32'd0);

      // Fairness: three 1-byte packets queued at every requester.
      apply_reset();
      exp_order.delete();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) begin
            send(i, 8'(16 * i + r), 1'b1);
            exp_order.push_back(i);
         end
      wait_served("fair_all_served", 12, 400);
      for (int k = 0; k < 12; k++)
         if (k < served.size()) check("fair_order", 32'(served[k]), 32'(exp_order[k]));

      // Single 3-byte packet from requester 2.
      apply_reset();
      send(2, 8'h48, 1'b0);
      send(2, 8'h69, 1'b0);
      send(2, 8'h0A, 1'b1);
      wait_served("pkt_three_acks", 3, 200);
      for (int k = 0; k < served.size(); k++) check("pkt_owner", 32'(served[k]), 32'd2);
      wait_busy_fall("pkt_busy_fall", 50);
      check("pkt_grant_held", 32'(bus.grant), 32'h4);
      tick();
      check("pkt_grant_released", 32'(bus.grant), 32'h0);
      check("pkt_owner_kept", 32'(bus.owner), 32'd2);
      repeat (5) tick();
      check("pkt_no_extra_ack", 32'(served.size()), 32'd3);

      // Packet lock and handover: requester 1 mid-packet, 0 and 3 arrive.
      apply_reset();
      send(1, 8'h11, 1'b0);
      send(1, 8'h12, 1'b0);
      send(1, 8'h13, 1'b1);
      wait_served("lock_first", 1, 50);
      send(0, 8'h20, 1'b1);
      send(3, 8'h30, 1'b1);
      wait_served("lock_packet", 3, 200);
      wait_busy_fall("lock_busy_fall", 50);
      check("lock_grant_held", 32'(bus.grant), 32'h2);
      tick();
      check("lock_grant_released", 32'(bus.grant), 32'h0);
      tick();
      check("lock_handover", 32'(bus.grant), 32'h8);
      wait_served("lock_all", 5, 200);
      exp_order = '{1, 1, 1, 3, 0};
      for (int k = 0; k < 5; k++)
         if (k < served.size()) check("lock_order", 32'(served[k]), 32'(exp_order[k]));

      // Idle timeout: requester 3 sends a non-last byte and goes quiet.
      apply_reset();
      send(3, 8'h33, 1'b0);
      wait_served("tmo_byte", 1, 50);
      send(0, 8'h44, 1'b1);
      wait_busy_fall("tmo_busy_fall", 50);
      repeat (TMO) tick();
      check("tmo_still_locked", 32'(bus.grant), 32'h8);
      tick();
      check("tmo_released", 32'(bus.grant), 32'h0);
      tick();
      check("tmo_next_grant", 32'(bus.grant), 32'h1);

      // Asynchronous reset while draining, with ptr moved away from 0.
      apply_reset();
      send(2, 8'h5A, 1'b1);
      wait_served("arst_setup", 1, 50);
      wait_grant("arst_setup_release", 1'b1, 50);
      send(1, 8'h51, 1'b0);
      send(1, 8'h52, 1'b1);
      wait_served("arst_first", 2, 60);
      tick();
      tick();
      #1;
      resetn = 1'b0;
      #1;
      check("arst_outputs", 32'({bus.grant, bus.ack, bus.tx_en, bus.owner}), 32'd0);
      clear_model();
      tick();
      @(negedge CLK);
      resetn = 1'b1;
      send(0, 8'h61, 1'b1);
      send(3, 8'h63, 1'b1);
      wait_grant("arst_regrant", 1'b0, 20);
      check("arst_restart_ptr0", 32'(bus.grant), 32'h1);

      // Table: ptr placement followed by a simultaneous request mask.
      for (int v = 0; v < 6; v++) begin
         apply_reset();
         if (vecs[v].setup >= 0) begin
            send(vecs[v].setup, 8'hB0, 1'b1);
            wait_served("vec_setup", 1, 50);
            wait_grant("vec_setup_release", 1'b1, 50);
         end
         for (int i = 0; i < N; i++) if (vecs[v].mask[i]) send(i, 8'hC0 + 8'(i), 1'b1);
         wait_grant("vec_grant_wait", 1'b0, 20);
         check("vec_grant", 32'(bus.grant), 32'(vecs[v].exp_grant));
         check("vec_owner", 32'(bus.owner), 32'(vecs[v].exp_owner));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
